p_bypass_module: RTL and testbench

Programmable cycle-count timer for the IPPro datapath bypass path. A load pulse captures a 16-bit cycle count. The block counts it down one per clock and emits a one-cycle TERMINATE pulse when the count expires. Upstream control uses this pulse to end a pixel-bypass window of a known length.

---
 rtl/ippro_bypass_pkg.sv | 14 +
 rtl/bypass_down_counter.sv | 38 +++
 rtl/p_bypass_module.sv | 83 ++++++++
 tb/tb_p_bypass_module.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/ippro_bypass_pkg.sv
// ippro_bypass_pkg
// Shared definitions for the IPPro bypass-window timer.
//   COUNT_W_DEFAULT : default width of the loaded cycle count and the counter
//   state_t         : timer FSM states (IDLE, COUNT)
package ippro_bypass_pkg;

  localparam int COUNT_W_DEFAULT = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/bypass_down_counter.sv
// bypass_down_counter
// Loadable unsigned down counter that saturates at zero.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : capture value into the counter (has priority over decrement)
//   value      : value to load
//   dec_en     : decrement by one when the count is non-zero
//   is_zero    : count equals 0
//   is_one     : count equals 1
module bypass_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         dec_en,
  output logic         is_zero,
  output logic         is_one
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= value;
    end else if (dec_en && (cnt_reg != '0)) begin
      // Never wraps: decrement only from a non-zero count.
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign is_zero = (cnt_reg == '0);
  assign is_one  = (cnt_reg == W'(1));

endmodule

// File: rtl/p_bypass_module.sv
// p_bypass_module
// Programmable cycle-count timer for the IPPro datapath bypass path. A load
// captures a cycle count N; TERMINATE pulses for one cycle N clock edges
// after the load edge (a count of 0 behaves like 1). A new load restarts the
// timer and suppresses the pulse of the count it replaces.
// Ports:
//   CLK         : system clock, rising edge
//   RESET       : asynchronous active-low reset
//   LOAD_COUNT  : load strobe
//   COUNT_VALUE : cycle count N, sampled when LOAD_COUNT=1
//   TERMINATE   : registered one-cycle expiry pulse
module p_bypass_module
  import ippro_bypass_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEFAULT
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               LOAD_COUNT,
  input  logic [COUNT_W-1:0] COUNT_VALUE,
  output logic               TERMINATE
);

  state_t state_reg;
  logic   terminate_reg;
  // A zero-length load stays in IDLE but owes a pulse on the following edge.
  logic   zero_pend_reg;
  logic   cnt_zero;
  logic   cnt_one;
  logic   dec_en;

  assign dec_en = (state_reg == COUNT) && !LOAD_COUNT;

  bypass_down_counter #(
    .W(COUNT_W)
  ) u_counter (
    .clk     (CLK),
    .rst_n   (RESET),
    .load    (LOAD_COUNT),
    .value   (COUNT_VALUE),
    .dec_en  (dec_en),
    .is_zero (cnt_zero),
    .is_one  (cnt_one)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg     <= IDLE;
      terminate_reg <= 1'b0;
      zero_pend_reg <= 1'b0;
    end else begin
      terminate_reg <= 1'b0;
      zero_pend_reg <= 1'b0;
      if (LOAD_COUNT) begin
        // Load wins over any expiry due this edge, including a pending zero load.
        if (COUNT_VALUE == '0) begin
          state_reg     <= IDLE;
          zero_pend_reg <= 1'b1;
        end else begin
          state_reg <= COUNT;
        end
      end else if (zero_pend_reg) begin
        terminate_reg <= 1'b1;
      end else begin
        case (state_reg)
          COUNT: begin
            if (cnt_one) begin
              state_reg     <= IDLE;
              terminate_reg <= 1'b1;
            end else if (cnt_zero) begin
              // Unreachable in normal operation; recover to IDLE silently.
              state_reg <= IDLE;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign TERMINATE = terminate_reg;

endmodule

// File: tb/tb_p_bypass_module.sv
// tb_p_bypass_module
// Randomized and directed stimulus for p_bypass_module. The reference model
// keeps one absolute "expiry edge" number: a load at edge E with value N sets
// it to E + max(N,1); any later load replaces it; reset cancels it. The
// expected TERMINATE after each edge is pushed into a queue; a monitor pops
// and compares on every falling edge.
module tb_p_bypass_module;

  localparam int W = 16;

  logic         CLK;
  logic         RESET;
  logic         LOAD_COUNT;
  logic [W-1:0] COUNT_VALUE;
  logic         TERMINATE;

  int   errors = 0;
  int   checks = 0;
  bit   exp_q[$];
  longint edge_n = 0;
  longint deadline = -1;
  int   load_cnt = 0;

  p_bypass_module #(.COUNT_W(W)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .LOAD_COUNT  (LOAD_COUNT),
    .COUNT_VALUE (COUNT_VALUE),
    .TERMINATE   (TERMINATE)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Monitor: compare DUT output against the queued expectation each cycle.
  initial begin
    forever begin
      @(negedge CLK);
      if (exp_q.size() != 0) begin
        bit e;
        e = exp_q.pop_front();
        checks++;
        if (TERMINATE !== e) begin
          errors++;
          $display("FAIL terminate edge=%0d got=%b exp=%b", edge_n, TERMINATE, e);
        end
      end
    end
  end

  // Drive one cycle of inputs, advance the model at the rising edge.
  task automatic step(input logic ld, input logic [W-1:0] v, input logic rst_val);
    RESET       = rst_val;
    LOAD_COUNT  = ld;
    COUNT_VALUE = v;
    @(posedge CLK);
    edge_n++;
    if (!rst_val) begin
      deadline = -1;
    end else if (ld) begin
      deadline = edge_n + ((v == 0) ? 1 : longint'(v));
      load_cnt++;
      $display("load #%0d N=%0d at edge %0d expires edge %0d", load_cnt, v, edge_n, deadline);
    end
    exp_q.push_back(deadline == edge_n);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, W'($urandom), 1'b1);
  endtask

  initial begin
    RESET = 1'b1; LOAD_COUNT = 1'b0; COUNT_VALUE = '0;
    #1 RESET = 1'b0;
    #1;
    checks++;
    if (TERMINATE !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got=%b exp=0", TERMINATE);
    end

    // Reset held with LOAD_COUNT toggling.
    for (int i = 0; i < 5; i++) step(1'(i % 2), W'(i), 1'b0);
    idle(4);

    // Basic count, then a second load after an idle gap.
    step(1'b1, 16'd5, 1'b1);
    idle(7);
    idle(5);
    step(1'b1, 16'd10, 1'b1);
    idle(12);

    // Restart: load 10, load 3 four cycles later.
    step(1'b1, 16'd10, 1'b1);
    idle(3);
    step(1'b1, 16'd3, 1'b1);
    idle(12);

    // Edge values 0 and 1, and back-to-back short loads.
    step(1'b1, 16'd0, 1'b1);
    idle(3);
    step(1'b1, 16'd1, 1'b1);
    idle(3);
    step(1'b1, 16'd0, 1'b1);
    step(1'b1, 16'd1, 1'b1);
    step(1'b1, 16'd0, 1'b1);
    idle(3);
    // Load arriving exactly when the old count would expire.
    step(1'b1, 16'd2, 1'b1);
    idle(1);
    step(1'b1, 16'd4, 1'b1);
    idle(6);

    // Reset mid-count: load 8, reset at cycle 4 for 2 cycles.
    step(1'b1, 16'd8, 1'b1);
    idle(3);
    step(1'b0, 16'd0, 1'b0);
    step(1'b1, 16'd2, 1'b0);
    idle(12);

    // Reset asserted while TERMINATE is high clears it at once.
    step(1'b1, 16'd2, 1'b1);
    idle(2);
    @(negedge CLK);
    #1 RESET = 1'b0;
    #1;
    checks++;
    if (TERMINATE !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_clear got=%b exp=0", TERMINATE);
    end
    step(1'b0, 16'd0, 1'b0);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0)
        step(1'b1, W'($urandom_range(0, 20)), 1'b1);
      else if ($urandom_range(0, 199) == 0)
        step(1'b0, W'($urandom), 1'b0);
      else
        step(1'b0, W'($urandom), 1'b1);
    end
    idle(25);

    // Maximum count: no wrap, single pulse after 65535 edges.
    step(1'b1, 16'hFFFF, 1'b1);
    idle(65540);

    @(negedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
